// File: rtl/pingpong_ball_score.sv
// ---------------------------------------------------------------------------
// pingpong_ball_score
//
// Datapath half of the ping-pong game. Takes the registered game state CS
// and produces the one-hot ball position LED[5:0] and the two BCD scores
// SCOREA/SCOREB that the state logic reads back. Player A serves from the
// bit0 end, player B from the bit5 end. All outputs are registered.
//
// Ports:
//   CLK     in   1  system clock, rising edge
//   RST     in   1  asynchronous, active-high reset
//   CS      in   3  current game state from the state register
//   LED     out  6  one-hot ball position (000000 = no ball shown)
//   SCOREA  out  4  player A score, BCD 0..9
//   SCOREB  out  4  player B score, BCD 0..9
//
// Optional feature macro: GAMEOVER_BLINK_EN
//   Defined   : in game over (101) LED toggles 111111 / 000000 every
//               BLINK_DIV clocks, starting at 111111 on entry.
//   Undefined : LED is dark in game over; BLINK_DIV is only range-checked.
// ---------------------------------------------------------------------------
module pingpong_ball_score #(
    parameter int SLOW_DIV  = 25000000,
    parameter int FAST_DIV  = 12500000,
    parameter int CNT_W     = 25,
    parameter int BLINK_DIV = 12500000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [2:0] CS,
    output logic [5:0] LED,
    output logic [3:0] SCOREA,
    output logic [3:0] SCOREB
);

    localparam logic [2:0] ST_IDLE    = 3'b000;
    localparam logic [2:0] ST_LEFT    = 3'b001;
    localparam logic [2:0] ST_RIGHT   = 3'b010;
    localparam logic [2:0] ST_A_PT    = 3'b011;
    localparam logic [2:0] ST_B_PT    = 3'b100;
    localparam logic [2:0] ST_OVER    = 3'b101;
    localparam logic [2:0] ST_LEFT_F  = 3'b110;
    localparam logic [2:0] ST_RIGHT_F = 3'b111;

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
`ifdef GAMEOVER_BLINK_EN
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);
`endif

    // Elaboration-time parameter sanity checks.
    if (FAST_DIV < 1 || FAST_DIV > SLOW_DIV) begin : g_bad_fast_div
        $error("FAST_DIV must be in 1..SLOW_DIV");
    end
    if (SLOW_DIV > (1 << CNT_W)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for SLOW_DIV-1");
    end
    if (BLINK_DIV < 1 || BLINK_DIV > (1 << CNT_W)) begin : g_bad_blink_div
        $error("BLINK_DIV must be >=1 and fit in CNT_W");
    end

    logic [5:0]       led_q, led_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pcs_q;
    logic [3:0]       score_a_q, score_a_d;
    logic [3:0]       score_b_q, score_b_d;

    logic [5:0]       led_left;
    logic [5:0]       led_right;
    logic             move_left;
    logic             move_fast;
    logic             cnt_wrap;
    logic [5:0]       serve_end;

    // One-position shifts with saturating end stops: the end bit ORs in its
    // neighbour and its own value, so the ball parks at the end, never wraps.
    genvar gi;
    for (gi = 0; gi < 6; gi++) begin : g_shift
        if (gi == 0) begin : g_low
            assign led_left[gi]  = 1'b0;
            assign led_right[gi] = led_q[0] | led_q[1];
        end else if (gi == 5) begin : g_high
            assign led_left[gi]  = led_q[4] | led_q[5];
            assign led_right[gi] = 1'b0;
        end else begin : g_mid
            assign led_left[gi]  = led_q[gi-1];
            assign led_right[gi] = led_q[gi+1];
        end
    end

    assign move_left = (CS == ST_LEFT) || (CS == ST_LEFT_F);
    assign move_fast = (CS == ST_LEFT_F) || (CS == ST_RIGHT_F);
    assign cnt_wrap  = (cnt_q == (move_fast ? FAST_LAST : SLOW_LAST));
    // Where a ball with no position re-enters: the end it moves away from.
    assign serve_end = move_left ? 6'b000001 : 6'b100000;

    always_comb begin
        led_d     = led_q;
        cnt_d     = cnt_q;
        score_a_d = score_a_q;
        score_b_d = score_b_q;
        case (CS)
            ST_LEFT, ST_LEFT_F, ST_RIGHT, ST_RIGHT_F: begin
                if (pcs_q != CS) begin
                    // Segment start: serve from idle, otherwise reverse in place.
                    cnt_d = '0;
                    if (pcs_q == ST_IDLE && CS == ST_LEFT) begin
                        led_d = 6'b000001;
                    end else if (pcs_q == ST_IDLE && CS == ST_RIGHT) begin
                        led_d = 6'b100000;
                    end else if (led_q == 6'b000000) begin
                        led_d = serve_end;
                    end
                end else begin
                    cnt_d = cnt_wrap ? '0 : cnt_q + 1'b1;
                    if (led_q == 6'b000000) begin
                        led_d = serve_end;
                    end else if (cnt_wrap) begin
                        led_d = move_left ? led_left : led_right;
                    end
                end
            end
            ST_A_PT: begin
                led_d = '0;
                cnt_d = '0;
                if (pcs_q != ST_A_PT && score_a_q != 4'd9) begin
                    score_a_d = score_a_q + 4'd1;
                end
            end
            ST_B_PT: begin
                led_d = '0;
                cnt_d = '0;
                if (pcs_q != ST_B_PT && score_b_q != 4'd9) begin
                    score_b_d = score_b_q + 4'd1;
                end
            end
            ST_OVER: begin
`ifdef GAMEOVER_BLINK_EN
                if (pcs_q != ST_OVER) begin
                    led_d = 6'b111111;
                    cnt_d = '0;
                end else if (cnt_q == BLINK_LAST) begin
                    led_d = ~led_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                led_d = '0;
                cnt_d = '0;
`endif
            end
            ST_IDLE: begin
                led_d = '0;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            led_q     <= '0;
            cnt_q     <= '0;
            pcs_q     <= ST_IDLE;
            score_a_q <= '0;
            score_b_q <= '0;
        end else begin
            led_q     <= led_d;
            cnt_q     <= cnt_d;
            pcs_q     <= CS;
            score_a_q <= score_a_d;
            score_b_q <= score_b_d;
        end
    end

    assign LED    = led_q;
    assign SCOREA = score_a_q;
    assign SCOREB = score_b_q;

endmodule
